// File: rtl/video_display_pkg.sv
// Shared colour constants, block palette and block start-position helpers
// for the multi-block bouncing display.
package video_display_pkg;

  typedef logic [23:0] rgb888_t;

  localparam rgb888_t BLUE  = 24'h0000FF;
  localparam rgb888_t BLACK = 24'h000000;
  localparam rgb888_t WHITE = 24'hFFFFFF;

  // GREEN, RED, YELLOW, CYAN, MAGENTA, ORANGE, WHITE, GREY
  localparam rgb888_t PALETTE [0:7] = '{
    24'h00FF00, 24'hFF0000, 24'hFFFF00, 24'h00FFFF,
    24'hFF00FF, 24'hFFA500, WHITE,      24'h808080
  };

  function automatic logic [11:0] init_x(input int idx, input int side_w, input int block_w);
    return 12'(side_w + 2 * idx * block_w);
  endfunction

  function automatic logic [11:0] init_y(input int idx, input int side_w, input int block_w);
    return 12'(side_w + idx * block_w);
  endfunction

endpackage

// File: rtl/video_block_mover.sv
// One bouncing block: position, direction, hit test and bounce detection.
// Optional post-bounce colour flash when VIDEO_BLOCK_FLASH_EN is defined.
module video_block_mover
  import video_display_pkg::*;
#(
  parameter int H_DISP  = 1280,
  parameter int V_DISP  = 720,
  parameter int SIDE_W  = 40,
  parameter int BLOCK_W = 40,
  parameter int STEP    = 1,
  parameter int IDX     = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_apply,
  input  logic        i_frame_sync,
  input  logic [10:0] i_xpos,
  input  logic [10:0] i_ypos,
  output logic        o_hit,
  output logic        o_bounced,
  output logic        o_flash
);

  localparam logic [11:0] LO   = 12'(SIDE_W);
  localparam logic [11:0] HI_X = 12'(H_DISP - SIDE_W - BLOCK_W);
  localparam logic [11:0] HI_Y = 12'(V_DISP - SIDE_W - BLOCK_W);
  localparam logic [11:0] STP  = 12'(STEP);
  localparam logic [11:0] BW   = 12'(BLOCK_W);

  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_hdir;
  logic        r_vdir;

  logic [11:0] w_nx;
  logic [11:0] w_ny;
  logic        w_hb;
  logic        w_vb;
  logic [11:0] w_xe;
  logic [11:0] w_ye;

  // Bounds are tested before stepping so the low side never underflows.
  always_comb begin
    w_nx = r_x;
    w_hb = 1'b0;
    if (r_hdir) begin
      if (r_x + STP >= HI_X) begin
        w_nx = HI_X;
        w_hb = 1'b1;
      end else begin
        w_nx = r_x + STP;
      end
    end else begin
      if (r_x <= LO + STP) begin
        w_nx = LO;
        w_hb = 1'b1;
      end else begin
        w_nx = r_x - STP;
      end
    end

    w_ny = r_y;
    w_vb = 1'b0;
    if (r_vdir) begin
      if (r_y + STP >= HI_Y) begin
        w_ny = HI_Y;
        w_vb = 1'b1;
      end else begin
        w_ny = r_y + STP;
      end
    end else begin
      if (r_y <= LO + STP) begin
        w_ny = LO;
        w_vb = 1'b1;
      end else begin
        w_ny = r_y - STP;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= init_x(IDX, SIDE_W, BLOCK_W);
      r_y    <= init_y(IDX, SIDE_W, BLOCK_W);
      r_hdir <= (IDX % 2 == 0);
      r_vdir <= 1'b1;
    end else if (i_apply) begin
      r_x    <= w_nx;
      r_y    <= w_ny;
      r_hdir <= r_hdir ^ w_hb;
      r_vdir <= r_vdir ^ w_vb;
    end
  end

  assign o_bounced = i_apply & (w_hb | w_vb);

  assign w_xe  = {1'b0, i_xpos};
  assign w_ye  = {1'b0, i_ypos};
  assign o_hit = (w_xe >= r_x) && (w_xe < r_x + BW) &&
                 (w_ye >= r_y) && (w_ye < r_y + BW);

`ifdef VIDEO_BLOCK_FLASH_EN
  logic [2:0] r_flash;

  // Counts frames, not moves, so it keeps running while motion is paused.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flash <= 3'd0;
    end else if (o_bounced) begin
      r_flash <= 3'd7;
    end else if (i_frame_sync && (r_flash != 3'd0)) begin
      r_flash <= r_flash - 3'd1;
    end
  end

  assign o_flash = (r_flash != 3'd0);
`else
  logic w_unused_fs;
  assign w_unused_fs = i_frame_sync;
  assign o_flash     = 1'b0;
`endif

endmodule

// File: rtl/video_multi_block_display.sv
// Border plus N_BLK bouncing blocks, moves applied only on frame_sync.
// Define VIDEO_BLOCK_FLASH_EN to invert a block's colour for 7 frames after it bounces.
module video_multi_block_display
  import video_display_pkg::*;
#(
  parameter int H_DISP   = 1280,
  parameter int V_DISP   = 720,
  parameter int SIDE_W   = 40,
  parameter int BLOCK_W  = 40,
  parameter int N_BLK    = 4,
  parameter int STEP     = 1,
  parameter int MOVE_DIV = 742500
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        frame_sync,
  input  logic        pause,
  output logic [23:0] pixel_data,
  output logic [15:0] bounce_cnt
);

  localparam int HI_X  = H_DISP - SIDE_W - BLOCK_W;
  localparam int HI_Y  = V_DISP - SIDE_W - BLOCK_W;
  localparam int DIV_W = $clog2(MOVE_DIV);

  if (N_BLK < 1 || N_BLK > 8) begin : g_bad_nblk
    $error("N_BLK must be in 1..8");
  end
  if (SIDE_W + 2 * (N_BLK - 1) * BLOCK_W > HI_X) begin : g_bad_x
    $error("block start positions exceed HI_X");
  end
  if (SIDE_W + (N_BLK - 1) * BLOCK_W > HI_Y) begin : g_bad_y
    $error("block start positions exceed HI_Y");
  end
  if (MOVE_DIV < 2) begin : g_bad_div
    $error("MOVE_DIV must be at least 2");
  end

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pending;
  logic [15:0]      r_bounce_cnt;
  rgb888_t          r_pixel;

  logic             w_tick;
  logic             w_apply;
  logic [16:0]      w_bounce_sum;
  logic [N_BLK-1:0] w_bounced;
  logic             w_border;
  logic [11:0]      w_x;
  logic [11:0]      w_y;
  rgb888_t          w_chain [0:N_BLK];

  assign w_tick = (r_div_cnt == DIV_W'(MOVE_DIV - 1));
  // A tick coinciding with frame_sync counts as pending in that same cycle.
  assign w_apply = frame_sync & ~pause & (r_pending | w_tick);

  assign w_bounce_sum = {1'b0, r_bounce_cnt} + 17'($countones(w_bounced));

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div_cnt    <= '0;
      r_pending    <= 1'b0;
      r_bounce_cnt <= 16'd0;
    end else begin
      if (!pause) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      end
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (w_tick && !pause) begin
        r_pending <= 1'b1;
      end
      if (w_apply) begin
        r_bounce_cnt <= w_bounce_sum[16] ? 16'hFFFF : w_bounce_sum[15:0];
      end
    end
  end

  // Colour chain: the lowest-index hitting block wins.
  assign w_chain[N_BLK] = BLACK;

  for (genvar i = 0; i < N_BLK; i++) begin : g_blk
    logic w_hit;
    logic w_flash;

    video_block_mover #(
      .H_DISP  (H_DISP),
      .V_DISP  (V_DISP),
      .SIDE_W  (SIDE_W),
      .BLOCK_W (BLOCK_W),
      .STEP    (STEP),
      .IDX     (i)
    ) u_mover (
      .i_clk        (pixel_clk),
      .i_rst_n      (sys_rst_n),
      .i_apply      (w_apply),
      .i_frame_sync (frame_sync),
      .i_xpos       (pixel_xpos),
      .i_ypos       (pixel_ypos),
      .o_hit        (w_hit),
      .o_bounced    (w_bounced[i]),
      .o_flash      (w_flash)
    );

    assign w_chain[i] = w_hit ? (w_flash ? ~PALETTE[i] : PALETTE[i]) : w_chain[i+1];
  end

  assign w_x      = {1'b0, pixel_xpos};
  assign w_y      = {1'b0, pixel_ypos};
  assign w_border = (w_x < 12'(SIDE_W)) || (w_x >= 12'(H_DISP - SIDE_W)) ||
                    (w_y < 12'(SIDE_W)) || (w_y >= 12'(V_DISP - SIDE_W));

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pixel <= BLACK;
    end else begin
      r_pixel <= w_border ? BLUE : w_chain[0];
    end
  end

  assign pixel_data = r_pixel;
  assign bounce_cnt = r_bounce_cnt;

endmodule
